prbs_multi_checker: RTL and testbench

//  Parametrised self-synchronising PRBS checker for GT receive words; successor to the fixed PRBS7 checker.

---
 rtl/prbs_multi_checker.sv | 214 +++++++++++++++++++++
 tb/tb_prbs_multi_checker.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_multi_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : prbs_multi_checker                                              |
// | Purpose  : Self-synchronising PRBS7/15/23/31 checker for GT receive words. |
// |            LSB-first stream (din[0] is the oldest bit of the word); lock   |
// |            FSM; clearable saturating error counters.                       |
// | Ports    : clk          receive user clock                                 |
// |            reset        synchronous active-low reset                       |
// |            en           din valid this cycle                               |
// |            mode         0=PRBS7 1=PRBS15 2=PRBS23 3=PRBS31                  |
// |            din          received word                                      |
// |            clear_cnt    clear tot_err_cnt, err_word_cnt, cnt_sat           |
// |            locked       checker is in LOCKED                               |
// |            error_flag   last checked word had a mismatch                   |
// |            err_bits     per-bit mismatch mask of last checked word         |
// |            word_errs    popcount of err_bits                               |
// |            tot_err_cnt  mismatched bits accumulated while locked           |
// |            err_word_cnt errored words accumulated while locked             |
// |            cnt_sat      sticky: a counter reached all-ones                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module prbs_multi_checker #(
  parameter int WORDWIDTH    = 64,
  parameter int CNT_W        = 32,
  parameter int LOCK_WORDS   = 16,
  parameter int UNLOCK_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WORDWIDTH-1:0] din,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 error_flag,
  output logic [WORDWIDTH-1:0] err_bits,
  output logic [7:0]           word_errs,
  output logic [CNT_W-1:0]     tot_err_cnt,
  output logic [CNT_W-1:0]     err_word_cnt,
  output logic                 cnt_sat
);

  localparam int SW = WORDWIDTH + 31;
  localparam int GW = $clog2(LOCK_WORDS + 1);
  localparam int BW = $clog2(UNLOCK_WORDS + 1);
  // Adder width wide enough for both the counter and an 8-bit popcount.
  localparam int AW = ((CNT_W > 8) ? CNT_W : 8) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [AW-1:0]    CNT_MAX_EXT = {{(AW-CNT_W){1'b0}}, CNT_MAX};

  typedef enum logic [1:0] {
    ST_PRIME  = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q;
  logic [30:0]           hist_q, hist_d;
  logic [GW-1:0]         good_q, good_d;
  logic [BW-1:0]         bad_q, bad_d;
  logic [CNT_W-1:0]      tot_d, ewc_d;
  logic                  sat_d;

  logic [SW-1:0]         stream;
  logic [WORDWIDTH-1:0]  pred;
  logic [WORDWIDTH-1:0]  mis;
  logic [7:0]            mis_cnt;
  logic                  mis_word;
  logic                  mode_chg;
  logic                  take;
  logic                  compare;
  logic                  count_word;
  logic [AW-1:0]         tot_sum;

  // Stream position 31+i holds din[i]; positions 0..30 are the previous bits.
  assign stream     = {din, hist_q};
  assign mode_chg   = (mode != mode_q);
  assign take       = en && !mode_chg;
  assign compare    = take && (state_q != ST_PRIME);
  assign count_word = compare && (state_q == ST_LOCKED);
  assign locked     = (state_q == ST_LOCKED);

  always_comb begin
    pred = '0;
    for (int i = 0; i < WORDWIDTH; i++) begin
      case (mode_q)
        2'd0:    pred[i] = stream[31+i-7]  ^ stream[31+i-6];
        2'd1:    pred[i] = stream[31+i-15] ^ stream[31+i-14];
        2'd2:    pred[i] = stream[31+i-23] ^ stream[31+i-18];
        default: pred[i] = stream[31+i-31] ^ stream[31+i-28];
      endcase
    end
  end

  assign mis      = din ^ pred;
  assign mis_word = |mis;

  always_comb begin
    mis_cnt = 8'd0;
    for (int i = 0; i < WORDWIDTH; i++) begin
      mis_cnt = mis_cnt + {7'd0, mis[i]};
    end
  end

  // The newest 31 stream bits become the history (works for any width).
  always_comb begin
    hist_d = hist_q;
    if (mode_chg) begin
      hist_d = '0;
    end else if (en) begin
      hist_d = stream[SW-1 -: 31];
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    if (mode_chg) begin
      state_d = ST_PRIME;
      good_d  = '0;
      bad_d   = '0;
    end else if (en) begin
      case (state_q)
        ST_PRIME: begin
          state_d = ST_SEARCH;
          good_d  = '0;
          bad_d   = '0;
        end
        ST_SEARCH: begin
          if (mis_word) begin
            good_d = '0;
          end else if (good_q == GW'(LOCK_WORDS - 1)) begin
            state_d = ST_LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end
        ST_LOCKED: begin
          if (!mis_word) begin
            bad_d = '0;
          end else if (bad_q == BW'(UNLOCK_WORDS - 1)) begin
            state_d = ST_SEARCH;
            bad_d   = '0;
            good_d  = '0;
          end else begin
            bad_d = bad_q + BW'(1);
          end
        end
        default: state_d = ST_PRIME;
      endcase
    end
  end

  // Saturating counters; a clear in the same cycle discards the word's count.
  always_comb begin
    tot_sum = AW'(tot_err_cnt) + AW'(mis_cnt);
    tot_d   = tot_err_cnt;
    ewc_d   = err_word_cnt;
    sat_d   = cnt_sat;
    if (clear_cnt) begin
      tot_d = '0;
      ewc_d = '0;
      sat_d = 1'b0;
    end else if (count_word) begin
      tot_d = (tot_sum > CNT_MAX_EXT) ? CNT_MAX : tot_sum[CNT_W-1:0];
      if (mis_word) begin
        ewc_d = (err_word_cnt == CNT_MAX) ? CNT_MAX : err_word_cnt + CNT_W'(1);
      end
      if ((tot_d == CNT_MAX) || (ewc_d == CNT_MAX)) begin
        sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (!reset) begin
      state_q      <= ST_PRIME;
      hist_q       <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      err_bits     <= '0;
      word_errs    <= '0;
      error_flag   <= 1'b0;
      tot_err_cnt  <= '0;
      err_word_cnt <= '0;
      cnt_sat      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      tot_err_cnt  <= tot_d;
      err_word_cnt <= ewc_d;
      cnt_sat      <= sat_d;
      if (mode_chg) begin
        err_bits   <= '0;
        word_errs  <= '0;
        error_flag <= 1'b0;
      end else if (take) begin
        // The priming word only seeds the history and reports no errors.
        err_bits   <= compare ? mis      : '0;
        word_errs  <= compare ? mis_cnt  : 8'd0;
        error_flag <= compare ? mis_word : 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prbs_multi_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_prbs_multi_checker                                           |
// | Purpose  : Self-checking bench for prbs_multi_checker (W=64, CNT_W=4).     |
// |            A reference PRBS generator produces the stream; per-word        |
// |            expectations go to a scoreboard queue checked by a monitor.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_prbs_multi_checker;

  localparam int W  = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [W-1:0]  din = '0;
  logic          clear_cnt = 1'b0;
  logic          locked;
  logic          error_flag;
  logic [W-1:0]  err_bits;
  logic [7:0]    word_errs;
  logic [CW-1:0] tot_err_cnt;
  logic [CW-1:0] err_word_cnt;
  logic          cnt_sat;

  prbs_multi_checker #(
    .WORDWIDTH   (W),
    .CNT_W       (CW),
    .LOCK_WORDS  (16),
    .UNLOCK_WORDS(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .mode        (mode),
    .din         (din),
    .clear_cnt   (clear_cnt),
    .locked      (locked),
    .error_flag  (error_flag),
    .err_bits    (err_bits),
    .word_errs   (word_errs),
    .tot_err_cnt (tot_err_cnt),
    .err_word_cnt(err_word_cnt),
    .cnt_sat     (cnt_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] bits;
    logic [7:0]   cnt;
    logic         flag;
    logic         chk;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [30:0]  gen = '1;       // reference generator, gen[30] newest bit
  logic [W-1:0] prev_flip = '0;
  bit           prime = 1'b1;
  logic         mon_v;

  function automatic void get_ab(input logic [1:0] m, output int a, output int b);
    case (m)
      2'd0:    begin a = 7;  b = 6;  end
      2'd1:    begin a = 15; b = 14; end
      2'd2:    begin a = 23; b = 18; end
      default: begin a = 31; b = 28; end
    endcase
  endfunction

  task automatic gen_word(output logic [W-1:0] w);
    int a, b;
    logic nb;
    get_ab(mode, a, b);
    for (int i = 0; i < W; i++) begin
      nb   = gen[31-a] ^ gen[31-b];
      w[i] = nb;
      gen  = {nb, gen[30:1]};
    end
  endtask

  // A clean stream satisfies the recurrence, so mismatches depend only on the
  // injected error pattern: m[n] = e[n] ^ e[n-A] ^ e[n-B].
  function automatic logic [W-1:0] exp_mask(input logic [W-1:0] flip,
                                            input logic [W-1:0] pflip,
                                            input logic [1:0] m);
    logic [2*W-1:0] es;
    logic [W-1:0]   r;
    int a, b;
    get_ab(m, a, b);
    es = {flip, pflip};
    for (int i = 0; i < W; i++) r[i] = es[W+i] ^ es[W+i-a] ^ es[W+i-b];
    return r;
  endfunction

  // Drives one cycle; entered and left at posedge+1.
  task automatic drive(input logic v, input logic [W-1:0] flip, input logic clr);
    exp_t e;
    logic [W-1:0] w;
    en        = v;
    clear_cnt = clr;
    if (v) begin
      gen_word(w);
      din    = w ^ flip;
      e.chk  = !prime;
      e.bits = prime ? '0 : exp_mask(flip, prev_flip, mode);
      e.cnt  = 8'($countones(e.bits));
      e.flag = |e.bits;
      exp_q.push_back(e);
      prev_flip = flip;
      prime     = 1'b0;
    end else begin
      din = {$urandom, $urandom};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en    = 1'b0;
    clear_cnt = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    prime     = 1'b1;
    prev_flip = '0;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (locked !== 1'b0 || error_flag !== 1'b0 || err_bits !== '0 || word_errs !== 8'd0 ||
        tot_err_cnt !== '0 || err_word_cnt !== '0 || cnt_sat !== 1'b0) begin
      errors++;
      $display("FAIL %s: locked=%b flag=%b bits=%h werrs=%0d tot=%0d ewc=%0d sat=%b, all required 0",
               name, locked, error_flag, err_bits, word_errs, tot_err_cnt, err_word_cnt, cnt_sat);
    end
  endtask

  task automatic check_cnt(input string name, input int tot, input int ewc,
                           input logic sat, input logic lk);
    checks++;
    if (tot_err_cnt !== CW'(tot) || err_word_cnt !== CW'(ewc) || cnt_sat !== sat || locked !== lk) begin
      errors++;
      $display("FAIL %s: tot=%0d ewc=%0d sat=%b locked=%b, required tot=%0d ewc=%0d sat=%b locked=%b",
               name, tot_err_cnt, err_word_cnt, cnt_sat, locked, tot, ewc, sat, lk);
    end
  endtask

  // Scoreboard monitor: every valid word sampled out of reset pops one entry.
  always @(posedge clk) begin
    mon_v = reset && en;
    #2;
    if (mon_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: valid word with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) begin
          checks++;
          if (err_bits !== e.bits || word_errs !== e.cnt || error_flag !== e.flag) begin
            errors++;
            $display("FAIL scoreboard: bits=%h werrs=%0d flag=%b, required bits=%h werrs=%0d flag=%b",
                     err_bits, word_errs, error_flag, e.bits, e.cnt, e.flag);
          end
        end
      end
    end
  end

  // Feeds clean valid words from PRIME until locked (17 valid words).
  task automatic run_to_lock(input string name, input bit rnd);
    int nv = 0;
    int guard = 0;
    logic v;
    while (nv < 17 && guard < 300) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(v, '0, 1'b0);
      guard++;
      if (v) begin
        nv++;
        if (nv == 16) begin
          checks++;
          if (locked !== 1'b0) begin
            errors++;
            $display("FAIL %s early lock: locked=%b after 16 words, required 0", name, locked);
          end
        end
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL %s lock: locked=%b after %0d valid words, required 1", name, locked, nv);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    do_reset();
    check_zero("reset_state");
  endtask

  task automatic test_clean_stream();
    mode = 2'd0;
    gen  = '1;
    run_to_lock("prbs7_clean", 1'b0);
    for (int k = 0; k < 2000; k++) drive(1'b1, '0, 1'b0);
    check_cnt("prbs7_long_run", 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_single_flip();
    drive(1'b0, '0, 1'b1);
    drive(1'b1, 64'h20, 1'b0);
    checks++;
    if (err_bits !== 64'h1820 || word_errs !== 8'd3 || error_flag !== 1'b1) begin
      errors++;
      $display("FAIL single_flip: bits=%h werrs=%0d flag=%b, required 1820 3 1",
               err_bits, word_errs, error_flag);
    end
    check_cnt("single_flip_cnt", 3, 1, 1'b0, 1'b1);
    drive(1'b1, '0, 1'b0);
    checks++;
    if (error_flag !== 1'b0 || err_bits !== '0) begin
      errors++;
      $display("FAIL after_flip: flag=%b bits=%h, required 0", error_flag, err_bits);
    end
    check_cnt("after_flip_cnt", 3, 1, 1'b0, 1'b1);
  endtask

  task automatic test_unlock();
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b1, 64'h10_0000, 1'b0);
    check_cnt("three_bad", 9, 3, 1'b0, 1'b1);
    drive(1'b1, 64'h10_0000, 1'b0);
    check_cnt("fourth_bad_unlock", 12, 4, 1'b0, 1'b0);
    drive(1'b1, '0, 1'b0);
    check_cnt("clean_after_unlock", 12, 4, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) drive(1'b1, '0, 1'b0);
    check_cnt("relock_from_search", 12, 4, 1'b0, 1'b1);
  endtask

  task automatic test_saturation();
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 64'h10_0000, 1'b0);
      drive(1'b1, '0, 1'b0);
    end
    check_cnt("saturate_no_wrap", 15, 6, 1'b1, 1'b1);
    drive(1'b1, 64'h10_0000, 1'b1);
    check_cnt("clear_wins", 0, 0, 1'b0, 1'b1);
    drive(1'b1, '0, 1'b0);
  endtask

  task automatic test_mode_sweep();
    logic [1:0] order [4];
    order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd3; order[3] = 2'd0;
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      mode      = order[k];
      gen       = '1;
      prime     = 1'b1;
      prev_flip = '0;
      drive(1'b0, '0, 1'b0);
      checks++;
      if (locked !== 1'b0) begin
        errors++;
        $display("FAIL mode_change_drop: locked=%b after mode %0d, required 0", locked, order[k]);
      end
      run_to_lock($sformatf("mode%0d", order[k]), 1'b1);
    end
    check_cnt("sweep_counts", 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 64'h20, 1'b0);
    check_cnt("pre_reset_counts", 3, 1, 1'b0, 1'b1);
    do_reset();
    check_zero("mid_reset");
    run_to_lock("relock_after_reset", 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_clean_stream();
    test_single_flip();
    test_unlock();
    test_saturation();
    test_mode_sweep();
    test_reset_mid();
    en = 1'b0;
    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
